// File: rtl/game_score_ctrl_if.sv
// Event/status bundle between the ball logic, the score counter and the game sequencer.
// The master side drives events and the counter digits. The slave side is the sequencer.
interface game_score_ctrl_if;
  logic       start;
  logic       hit;
  logic       miss;
  logic [3:0] dig0;
  logic [3:0] dig1;
  logic       score_up;
  logic       score_clr;
  logic       freeze;
  logic       game_over;
  logic [2:0] lives;
  logic [1:0] state;

  modport master (
    output start, hit, miss, dig0, dig1,
    input  score_up, score_clr, freeze, game_over, lives, state
  );

  modport slave (
    input  start, hit, miss, dig0, dig1,
    output score_up, score_clr, freeze, game_over, lives, state
  );
endinterface

// File: rtl/game_score_ctrl.sv
// Game-level sequencer: turns hit/miss events into score counter pulses.
// It also tracks lives and holds the game-over display for WAIT_CYCLES clock cycles.
module game_score_ctrl #(
  parameter int LIVES       = 3,
  parameter int WAIT_CYCLES = 100_000_000,
  parameter int TIMER_W     = 27
) (
  input  logic               clk,
  input  logic               reset,
  game_score_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    S_NEWGAME = 2'b00,
    S_PLAY    = 2'b01,
    S_NEWBALL = 2'b10,
    S_OVER    = 2'b11
  } state_e;

  localparam logic [2:0]         LIVES_INIT = 3'(LIVES);
  localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(WAIT_CYCLES - 1);

  state_e               state_q, state_d;
  logic [2:0]           lives_q, lives_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic                 start_d_q;
  logic                 score_up_q, score_up_d;
  logic                 score_clr_q, score_clr_d;
  logic                 freeze_q, freeze_d;
  logic                 game_over_q, game_over_d;
  logic                 start_edge;
  logic                 at_max;

  assign start_edge = bus.start & ~start_d_q;
  assign at_max     = (bus.dig1 == 4'd9) && (bus.dig0 == 4'd9);

  always_comb begin
    state_d     = state_q;
    lives_d     = lives_q;
    timer_d     = timer_q;
    score_up_d  = 1'b0;
    score_clr_d = 1'b0;
    case (state_q)
      S_NEWGAME: begin
        if (start_edge) begin
          state_d     = S_PLAY;
          lives_d     = LIVES_INIT;
          score_clr_d = 1'b1;
        end
      end
      S_PLAY: begin
        // A miss takes priority over a hit in the same cycle.
        if (bus.miss) begin
          lives_d = (lives_q == 3'd0) ? 3'd0 : lives_q - 3'd1;
          if (lives_q <= 3'd1) begin
            state_d = S_OVER;
            timer_d = TIMER_LOAD;
          end else begin
            state_d = S_NEWBALL;
          end
        end else if (bus.hit && !at_max) begin
          score_up_d = 1'b1;
        end
      end
      S_NEWBALL: begin
        if (start_edge) state_d = S_PLAY;
      end
      S_OVER: begin
        if (timer_q == '0) state_d = S_NEWGAME;
        else               timer_d = timer_q - 1'b1;
      end
      default: state_d = S_NEWGAME;
    endcase
    freeze_d    = (state_d != S_PLAY);
    game_over_d = (state_d == S_OVER);
  end

  // start_d resets high so that a button held through reset release does not count as a press.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_NEWGAME;
      lives_q     <= LIVES_INIT;
      timer_q     <= '0;
      start_d_q   <= 1'b1;
      score_up_q  <= 1'b0;
      score_clr_q <= 1'b0;
      freeze_q    <= 1'b1;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lives_q     <= lives_d;
      timer_q     <= timer_d;
      start_d_q   <= bus.start;
      score_up_q  <= score_up_d;
      score_clr_q <= score_clr_d;
      freeze_q    <= freeze_d;
      game_over_q <= game_over_d;
    end
  end

  assign bus.score_up  = score_up_q;
  assign bus.score_clr = score_clr_q;
  assign bus.freeze    = freeze_q;
  assign bus.game_over = game_over_q;
  assign bus.lives     = lives_q;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_game_score_ctrl.sv
// Scoreboard bench for game_score_ctrl. It uses directed events and a behavioural BCD score counter.
module tb_game_score_ctrl;

  logic clk = 1'b0;
  logic reset;
  game_score_ctrl_if bus();

  always #5 clk = ~clk;

  game_score_ctrl #(.LIVES(3), .WAIT_CYCLES(8), .TIMER_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    bit clr;
    int cyc;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  int   up_cnt = 0;

  logic       pre_en;
  logic [3:0] pre0, pre1;

  always @(posedge clk) cyc <= cyc + 1;

  // Score counter model: preset, clear, saturating BCD increment.
  always @(posedge clk) begin
    if (pre_en) begin
      bus.dig1 <= pre1;
      bus.dig0 <= pre0;
    end else if (bus.score_clr) begin
      bus.dig1 <= 4'd0;
      bus.dig0 <= 4'd0;
    end else if (bus.score_up && !(bus.dig1 == 4'd9 && bus.dig0 == 4'd9)) begin
      if (bus.dig0 == 4'd9) begin
        bus.dig0 <= 4'd0;
        bus.dig1 <= bus.dig1 + 4'd1;
      end else begin
        bus.dig0 <= bus.dig0 + 4'd1;
      end
    end
  end

  // Monitor: every pulse must match the next expected pulse in type and cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (bus.score_up) up_cnt++;
        if (bus.score_up && bus.score_clr) begin
          n_cmp++; n_fail++;
          $display("FAIL up_clr_overlap: up=1 clr=1 at cyc %0d, required never both", cyc);
        end
        if (bus.score_up || bus.score_clr) begin
          n_cmp++;
          if (sbq.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_pulse: up=%0b clr=%0b at cyc %0d, required no pulse",
                     bus.score_up, bus.score_clr, cyc);
          end else begin
            e = sbq.pop_front();
            if (e.clr != bus.score_clr || e.cyc != cyc) begin
              n_fail++;
              $display("FAIL pulse: got clr=%0b cyc=%0d, required clr=%0b cyc=%0d",
                       bus.score_clr, cyc, e.clr, e.cyc);
            end
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // One-cycle hit/miss event; if exp_up, a score_up is expected one cycle later.
  task automatic ev(input bit h, input bit m, input bit exp_up);
    @(negedge clk);
    bus.hit  = h;
    bus.miss = m;
    if (exp_up) sbq.push_back('{1'b0, cyc + 1});
    @(negedge clk);
    bus.hit  = 1'b0;
    bus.miss = 1'b0;
  endtask

  task automatic press(input bit exp_clr);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    if (exp_clr) sbq.push_back('{1'b1, cyc + 1});
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  initial begin
    int u0;
    int go_cnt;
    reset = 1'b1;
    bus.start = 1'b1;
    bus.hit = 1'b0;
    bus.miss = 1'b0;
    pre_en = 1'b1;
    pre0 = 4'd0;
    pre1 = 4'd0;
    repeat (3) @(negedge clk);
    chk("rst_state", bus.state, 0);
    chk("rst_lives", bus.lives, 3);
    chk("rst_freeze", bus.freeze, 1);
    chk("rst_game_over", bus.game_over, 0);
    chk("rst_up", bus.score_up, 0);
    chk("rst_clr", bus.score_clr, 0);

    // Start held through reset release: no edge.
    reset = 1'b0;
    pre_en = 1'b0;
    repeat (4) @(negedge clk);
    chk("held_start_state", bus.state, 0);

    press(1'b1);
    chk("play_state", bus.state, 1);
    chk("play_lives", bus.lives, 3);
    chk("play_freeze", bus.freeze, 0);

    // Five hits, two of them back to back.
    u0 = up_cnt;
    ev(1'b1, 1'b0, 1'b1);
    ev(1'b1, 1'b0, 1'b1);
    @(negedge clk);
    bus.hit = 1'b1;
    sbq.push_back('{1'b0, cyc + 1});
    @(negedge clk);
    sbq.push_back('{1'b0, cyc + 1});
    @(negedge clk);
    bus.hit = 1'b0;
    ev(1'b1, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    chk("five_hits_count", up_cnt - u0, 5);
    chk("five_hits_dig1", bus.dig1, 0);
    chk("five_hits_dig0", bus.dig0, 5);

    // Saturation at 99, then hit+miss together.
    @(negedge clk);
    pre_en = 1'b1;
    pre1 = 4'd9;
    pre0 = 4'd9;
    @(negedge clk);
    pre_en = 1'b0;
    u0 = up_cnt;
    ev(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("sat_no_up", up_cnt - u0, 0);
    chk("sat_dig", {bus.dig1, bus.dig0}, 8'h99);
    ev(1'b1, 1'b1, 1'b0);
    chk("hitmiss_lives", bus.lives, 2);
    chk("hitmiss_state", bus.state, 2);
    chk("newball_freeze", bus.freeze, 1);

    // Events ignored in NEWBALL.
    ev(1'b1, 1'b0, 1'b0);
    ev(1'b0, 1'b1, 1'b0);
    chk("newball_ign_lives", bus.lives, 2);
    chk("newball_ign_state", bus.state, 2);

    press(1'b0);
    chk("restart1_state", bus.state, 1);
    ev(1'b0, 1'b1, 1'b0);
    chk("miss2_lives", bus.lives, 1);
    chk("miss2_state", bus.state, 2);
    press(1'b0);
    chk("restart2_state", bus.state, 1);
    ev(1'b0, 1'b1, 1'b0);
    chk("miss3_lives", bus.lives, 0);
    chk("over_state", bus.state, 3);
    chk("over_flag", bus.game_over, 1);

    // Game-over dwell, with hits toggling throughout.
    go_cnt = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bus.hit = ~bus.hit;
      if (bus.game_over) go_cnt++;
      else break;
    end
    bus.hit = 1'b0;
    chk("over_dwell", go_cnt, 8);
    chk("over_exit_state", bus.state, 0);
    chk("over_lives_zero", bus.lives, 0);
    chk("over_score_held", {bus.dig1, bus.dig0}, 8'h99);

    ev(1'b1, 1'b0, 1'b0);
    ev(1'b1, 1'b0, 1'b0);
    chk("newgame_ign_state", bus.state, 0);
    chk("ignored_hits_up", up_cnt - u0, 0);

    press(1'b1);
    chk("game2_lives", bus.lives, 3);
    chk("game2_state", bus.state, 1);
    @(negedge clk);
    chk("game2_score_clr", {bus.dig1, bus.dig0}, 0);

    // Reset lands while a score_up pulse is in flight.
    @(negedge clk);
    bus.hit = 1'b1;
    @(posedge clk);
    #1;
    bus.hit = 1'b0;
    chk("inflight_up", bus.score_up, 1);
    reset = 1'b1;
    #1;
    chk("midrst_up", bus.score_up, 0);
    chk("midrst_state", bus.state, 0);
    chk("midrst_lives", bus.lives, 3);
    chk("midrst_freeze", bus.freeze, 1);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("queue_drained", sbq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
